// File: rtl/lin_interp_up.sv
// lin_interp_up: linear-interpolating upsampler.
// Each accepted input closes a segment that started at the previous input.
// The segment is played out as RATIO evenly spaced beats from prev toward cur.
// The endpoint cur itself is emitted as beat 0 of the following segment.
module lin_interp_up #(
  parameter int WIDTH = 16,
  parameter int RATIO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             primed
);

  localparam int LG = $clog2(RATIO);
  localparam int PW = WIDTH + LG + 1;

  typedef enum logic [1:0] {
    PRIME,
    WAIT,
    EMIT
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [WIDTH-1:0]  r_prev;
  logic [WIDTH-1:0]  r_cur;
  logic [LG-1:0]     r_k;

  logic              w_inAccept;
  logic              w_outFire;
  logic              w_lastBeat;
  logic [LG-1:0]     w_nextK;
  logic signed [WIDTH:0]  w_diff;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_step;
  logic signed [PW-1:0]   w_sum;
  logic [WIDTH-1:0]  w_interp;

  // The input side is only open while no segment is being played out.
  assign in_ready   = !rst && (r_state != EMIT);
  assign w_inAccept = in_valid && in_ready;
  assign w_outFire  = out_valid && out_ready;
  assign w_lastBeat = (r_k == LG'(RATIO - 1));
  assign w_nextK    = r_k + LG'(1);

  // The slope term is signed and one bit wider than a sample.
  // Multiplying by k < RATIO needs only LG more bits, so a full-scale swing cannot overflow.
  // The arithmetic shift floors toward -inf.
  // The result always lies between prev and cur, so truncating the sum is exact.
  assign w_diff   = $signed({1'b0, r_cur}) - $signed({1'b0, r_prev});
  assign w_prod   = PW'(w_diff) * PW'($signed({1'b0, w_nextK}));
  assign w_step   = w_prod >>> LG;
  assign w_sum    = $signed({{(LG + 1){1'b0}}, r_prev}) + w_step;
  assign w_interp = WIDTH'(w_sum);

  // State register; a reset always returns to waiting for a first sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PRIME;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: prime once, then alternate between waiting for an input and playing its segment.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      PRIME: if (w_inAccept) w_nextState = WAIT;
      WAIT:  if (w_inAccept) w_nextState = EMIT;
      EMIT:  if (w_outFire && w_lastBeat) w_nextState = WAIT;
      default: w_nextState = PRIME;
    endcase
  end

  // Datapath registers: endpoints, beat counter and the registered output beat.
  // out_valid and out_data hold their values until the consumer takes the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= '0;
      r_cur     <= '0;
      r_k       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      primed    <= 1'b0;
    end else begin
      case (r_state)
        PRIME: begin
          if (w_inAccept) begin
            r_prev <= in_data;
            primed <= 1'b1;
          end
        end
        WAIT: begin
          if (w_inAccept) begin
            r_cur     <= in_data;
            r_k       <= '0;
            out_valid <= 1'b1;
            out_data  <= r_prev;
          end
        end
        EMIT: begin
          if (w_outFire) begin
            if (w_lastBeat) begin
              out_valid <= 1'b0;
              r_prev    <= r_cur;
              r_k       <= '0;
            end else begin
              r_k      <= w_nextK;
              out_data <= w_interp;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
